// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and defaults for the UART transmit arbiter.
//   arb_state_t  : arbiter FSM states
//   DATA_W_DEF   : byte width of the UART data interface
//   TIMEOUT_DEF  : default watchdog limit in WAIT_DONE (cycles)
//   WDOG_W       : watchdog counter width
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        COOLDOWN
    } arb_state_t;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 4095;
    localparam int unsigned WDOG_W      = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker: first set request at or after the pointer,
// searching upward with wrap-around.
//   i_req    : request vector
//   i_ptr    : round-robin pointer (highest-priority index)
//   o_valid  : at least one request is set
//   o_onehot : one-hot winner (all zero when o_valid is low)
//   o_idx    : winner index
// -----------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx
);

    logic [2*NUM_REQ-1:0] w_masked;
    int unsigned          w_pos;

    // The request vector is duplicated; bits below the pointer are masked in
    // the lower copy only, so the lowest surviving bit is the wrap-around winner.
    always_comb begin
        w_masked = '0;
        for (int unsigned j = 0; j < 2 * NUM_REQ; j++) begin
            if (j >= NUM_REQ) begin
                w_masked[j] = i_req[j - NUM_REQ];
            end else begin
                w_masked[j] = i_req[j] && (j >= 32'(i_ptr));
            end
        end

        w_pos = 0;
        for (int unsigned j = 2 * NUM_REQ; j > 0; j--) begin
            if (w_masked[j-1]) begin
                w_pos = j - 1;
            end
        end

        o_valid  = |i_req;
        o_idx    = IDX_W'((w_pos >= NUM_REQ) ? (w_pos - NUM_REQ) : w_pos);
        o_onehot = '0;
        if (o_valid) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin sharing of one byte UART transmitter among NUM_REQ clients,
// with a watchdog that aborts a transfer the UART never completes.
//   clk, rst     : clock, synchronous active-high reset
//   req          : per-client request, held until gnt
//   req_data     : per-client byte, slice i = [i*DATA_W +: DATA_W]
//   gnt          : one-hot 1-cycle pulse, byte accepted
//   ack          : one-hot 1-cycle pulse, transfer completed or aborted
//   uart_data    : byte to the UART
//   uart_start   : 1-cycle start pulse to the UART
//   uart_done    : UART done status (level)
//   busy         : arbiter not in IDLE
//   owner        : index of current or last granted client
//   timeout_err  : 1-cycle pulse with the ack of an aborted transfer
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         uart_data,
    output logic                      uart_start,
    input  logic                      uart_done,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner,
    output logic                      timeout_err
);

    arb_state_t           r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_ack;
    logic [DATA_W-1:0]    r_data;
    logic                 r_start;
    logic                 r_terr;
    logic                 r_busy;
    logic                 r_done_q;
    logic [WDOG_W-1:0]    r_wdog;

    logic                 w_valid;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [IDX_W-1:0]     w_idx;
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic [WDOG_W-1:0]    w_wdog_inc;
    logic                 w_done_rise;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_onehot (w_onehot),
        .o_idx    (w_idx)
    );

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
        w_wdog_inc          = (r_wdog == '1) ? r_wdog : r_wdog + 1'b1;
        // A done level left over from the previous transfer is not a completion.
        w_done_rise         = uart_done && !r_done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_data   <= '0;
            r_start  <= 1'b0;
            r_terr   <= 1'b0;
            r_busy   <= 1'b0;
            r_done_q <= 1'b0;
            r_wdog   <= '0;
        end else begin
            r_done_q <= uart_done;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_start  <= 1'b0;
            r_terr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_data  <= req_data[w_idx*DATA_W +: DATA_W];
                        r_owner <= w_idx;
                        r_gnt   <= w_onehot;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_start <= 1'b1;
                    r_wdog  <= '0;
                    r_ptr   <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // Completion is checked first so it wins over a coincident timeout.
                    if (w_done_rise) begin
                        r_ack   <= w_owner_oh;
                        r_state <= COOLDOWN;
                    end else begin
                        r_wdog <= w_wdog_inc;
                        if (w_wdog_inc == WDOG_W'(TIMEOUT)) begin
                            r_ack   <= w_owner_oh;
                            r_terr  <= 1'b1;
                            r_state <= COOLDOWN;
                        end
                    end
                end
                COOLDOWN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign ack         = r_ack;
    assign uart_data   = r_data;
    assign uart_start  = r_start;
    assign busy        = r_busy;
    assign owner       = r_owner;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned TO   = 20;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     uart_data;
    logic              uart_start;
    logic              uart_done;
    logic              busy;
    logic [1:0]        owner;
    logic              timeout_err;

    int unsigned n_checks;
    int unsigned n_errors;

    uart_tx_arbiter #(
        .NUM_REQ (NREQ),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .ack         (ack),
        .uart_data   (uart_data),
        .uart_start  (uart_start),
        .uart_done   (uart_done),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic set_byte(input int unsigned idx, input logic [7:0] b);
        req_data[idx*DW +: DW] = b;
    endtask

    // One full transfer with a clean done pulse; requests are already driven.
    task automatic serve(input int unsigned idx, input logic [7:0] data, input bit drop);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        tick(1);
        check("gnt", 32'(gnt), 32'(oh));
        check("owner", 32'(owner), idx);
        check("uart_data", 32'(uart_data), 32'(data));
        check("busy_on", 32'(busy), 32'd1);
        if (drop) req[idx] = 1'b0;
        tick(1);
        check("uart_start", 32'(uart_start), 32'd1);
        check("gnt_clear", 32'(gnt), 32'd0);
        uart_done = 1'b1;
        tick(1);
        check("ack", 32'(ack), 32'(oh));
        check("terr_clear", 32'(timeout_err), 32'd0);
        uart_done = 1'b0;
        tick(1);
        check("ack_clear", 32'(ack), 32'd0);
        check("busy_off", 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        uart_done = 1'b0;
        tick(2);
        rst = 1'b0;

        // Reset state
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_start", 32'(uart_start), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(uart_data), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);

        // Single request, client 1, byte 0xA5
        set_byte(1, 8'hA5);
        req = 4'b0010;
        serve(1, 8'hA5, 1'b1);

        // Two simultaneous requests from pointer 0: order 0 then 2
        do_reset();
        set_byte(0, 8'h11);
        set_byte(2, 8'h33);
        req = 4'b0101;
        serve(0, 8'h11, 1'b1);
        serve(2, 8'h33, 1'b1);

        // All four continuously requesting: 0,1,2,3,0,1,2,3
        do_reset();
        for (int unsigned i = 0; i < NREQ; i++) set_byte(i, 8'(8'h40 + i));
        req = 4'b1111;
        for (int unsigned t = 0; t < 8; t++) begin
            serve(t % NREQ, 8'(8'h40 + (t % NREQ)), 1'b0);
        end
        req = '0;

        // Watchdog abort: client 3, done never rises (pointer back at 0)
        set_byte(3, 8'h77);
        req = 4'b1000;
        tick(1);
        check("to_gnt", 32'(gnt), 32'h8);
        req = '0;
        tick(1);
        check("to_start", 32'(uart_start), 32'd1);
        tick(TO - 1);
        check("to_ack_early", 32'(ack), 32'd0);
        check("to_terr_early", 32'(timeout_err), 32'd0);
        tick(1);
        check("to_ack", 32'(ack), 32'h8);
        check("to_terr", 32'(timeout_err), 32'd1);
        tick(1);
        check("to_terr_clear", 32'(timeout_err), 32'd0);
        check("to_busy_off", 32'(busy), 32'd0);

        // Next request after abort proceeds normally (pointer 0)
        set_byte(0, 8'h5A);
        req = 4'b0001;
        serve(0, 8'h5A, 1'b1);

        // Done left high from the previous transfer is not a completion
        set_byte(1, 8'h22);
        req = 4'b0010;
        tick(1);
        check("hd_gnt1", 32'(gnt), 32'h2);
        req = '0;
        tick(1);
        uart_done = 1'b1;
        tick(1);
        check("hd_ack1", 32'(ack), 32'h2);
        tick(1);
        set_byte(2, 8'h44);
        req = 4'b0100;
        tick(1);
        check("hd_gnt2", 32'(gnt), 32'h4);
        req = '0;
        tick(1);
        check("hd_start2", 32'(uart_start), 32'd1);
        check("hd_data2", 32'(uart_data), 32'h44);
        tick(3);
        check("hd_no_early_ack", 32'(ack), 32'd0);
        check("hd_still_busy", 32'(busy), 32'd1);
        uart_done = 1'b0;
        tick(1);
        check("hd_ack_low", 32'(ack), 32'd0);
        uart_done = 1'b1;
        tick(1);
        check("hd_ack2", 32'(ack), 32'h4);
        check("hd_data_hold", 32'(uart_data), 32'h44);
        uart_done = 1'b0;
        tick(1);

        // Done edge in the timeout cycle: completion wins
        set_byte(3, 8'h99);
        req = 4'b1000;
        tick(1);
        check("tw_gnt", 32'(gnt), 32'h8);
        req = '0;
        tick(1);
        tick(TO - 1);
        check("tw_ack_early", 32'(ack), 32'd0);
        uart_done = 1'b1;
        tick(1);
        check("tw_ack", 32'(ack), 32'h8);
        check("tw_terr", 32'(timeout_err), 32'd0);
        uart_done = 1'b0;
        tick(1);

        // Reset mid-WAIT_DONE with owner 2
        set_byte(2, 8'hC3);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(3);
        check("mr_owner_pre", 32'(owner), 32'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mr_gnt", 32'(gnt), 32'd0);
        check("mr_ack", 32'(ack), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_owner", 32'(owner), 32'd0);
        check("mr_data", 32'(uart_data), 32'd0);
        tick(1);
        check("mr_no_ack", 32'(ack), 32'd0);
        req = 4'b0100;
        serve(2, 8'hC3, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
